// File: rtl/out_mem_ctrl.sv
// Output pixel memory controller: buffers GP pixels in a small FIFO, writes them
// in order into a shared single-port memory, then streams the stored frame to a host.
module out_mem_ctrl #(
  parameter int PIX_COUNT  = 153600,
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_clr,
  input  logic              gp_valid,
  input  logic [DATA_W-1:0] gp_pixel,
  output logic              gp_ready,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              frame_done,
  input  logic              rd_start,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  input  logic              rd_ready,
  output logic [15:0]       frame_cnt
);
  localparam int CNT_W = $clog2(PIX_COUNT + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int FCW   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  PIX_FULL  = CNT_W'(PIX_COUNT);
  localparam logic [CNT_W-1:0]  PIX_LAST  = CNT_W'(PIX_COUNT - 1);
  localparam logic [ADDR_W-1:0] RD_LAST   = ADDR_W'(PIX_COUNT - 1);
  localparam logic [PTR_W:0]    FIFO_FULL = FCW'(FIFO_DEPTH);

  typedef enum logic [2:0] {FILL, DONE, RD_REQ, RD_WAIT, RD_OUT} state_t;

  state_t              state;
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wptr, rptr;
  logic [PTR_W:0]      fcount;
  logic [CNT_W-1:0]    acc_cnt, wr_cnt, wr_cnt_nx;
  logic [ADDR_W-1:0]   rd_addr;
  logic                fifo_empty, fifo_full;
  logic                push, wr_done, wr_final, issue, store, pop;
  logic [DATA_W-1:0]   issue_data;

  assign fifo_empty = (fcount == '0);
  assign fifo_full  = (fcount == FIFO_FULL);
  assign gp_ready   = (state == FILL) && !fifo_full && (acc_cnt < PIX_FULL);
  assign push       = gp_valid && gp_ready;
  assign wr_done    = mem_we && !mem_busy;
  assign wr_final   = wr_done && (wr_cnt == PIX_LAST);
  assign wr_cnt_nx  = wr_done ? wr_cnt + 1'b1 : wr_cnt;

  // A new write may be issued once the previous one is gone (or completing now).
  // An empty FIFO lets the incoming pixel bypass storage for single-cycle latency.
  assign issue      = (state == FILL) && (!mem_we || !mem_busy) && !wr_final &&
                      (!fifo_empty || push);
  assign pop        = issue && !fifo_empty;
  assign store      = push && !(issue && fifo_empty);
  assign issue_data = fifo_empty ? gp_pixel : fifo_mem[rptr];

  always_ff @(posedge clk) begin
    if (store) fifo_mem[wptr] <= gp_pixel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FILL;
      wptr       <= '0;
      rptr       <= '0;
      fcount     <= '0;
      acc_cnt    <= '0;
      wr_cnt     <= '0;
      rd_addr    <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      frame_done <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_last    <= 1'b0;
      frame_cnt  <= '0;
    end else if (soft_clr) begin
      state      <= FILL;
      wptr       <= '0;
      rptr       <= '0;
      fcount     <= '0;
      acc_cnt    <= '0;
      wr_cnt     <= '0;
      rd_addr    <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      frame_done <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_last    <= 1'b0;
    end else begin
      if (store) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      if (store && !pop)      fcount <= fcount + 1'b1;
      else if (!store && pop) fcount <= fcount - 1'b1;
      if (push) acc_cnt <= acc_cnt + 1'b1;
      wr_cnt <= wr_cnt_nx;

      case (state)
        FILL: begin
          if (wr_final) begin
            state      <= DONE;
            frame_done <= 1'b1;
            mem_we     <= 1'b0;
          end else if (issue) begin
            mem_we    <= 1'b1;
            mem_addr  <= ADDR_W'(wr_cnt_nx);
            mem_wdata <= issue_data;
          end else if (wr_done) begin
            mem_we <= 1'b0;
          end
        end
        DONE: begin
          if (rd_start) begin
            state    <= RD_REQ;
            rd_addr  <= '0;
            mem_re   <= 1'b1;
            mem_addr <= '0;
          end
        end
        RD_REQ: begin
          if (!mem_busy) begin
            state  <= RD_WAIT;
            mem_re <= 1'b0;
          end
        end
        RD_WAIT: begin
          rd_data  <= mem_rdata;
          rd_valid <= 1'b1;
          rd_last  <= (rd_addr == RD_LAST);
          state    <= RD_OUT;
        end
        RD_OUT: begin
          if (rd_ready) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            if (rd_last) begin
              state      <= FILL;
              acc_cnt    <= '0;
              wr_cnt     <= '0;
              rd_addr    <= '0;
              mem_addr   <= '0;
              frame_done <= 1'b0;
              frame_cnt  <= frame_cnt + 16'd1;
            end else begin
              state    <= RD_REQ;
              rd_addr  <= rd_addr + 1'b1;
              mem_addr <= rd_addr + 1'b1;
              mem_re   <= 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: doc/out_mem_ctrl.md
Name: out_mem_ctrl

Overview:
Controller sequencing the output pixel memory written by GP (OpCode 10) instructions leaving the MEM stage. It buffers GP pixels in a small FIFO and writes them sequentially into a shared single-port output memory, honouring a busy/stall signal from that port. It raises frame_done after PIX_COUNT pixels, then streams the whole frame out to a host reader. After the readout it re-arms for the next frame.

Parameters:
PIX_COUNT, 153600, pixels per frame (320x480, 8-bit).
ADDR_W, 18, output memory address width; must satisfy 2^ADDR_W >= PIX_COUNT.
DATA_W, 8, pixel width; the low DATA_W bits of the GP ALU result.
FIFO_DEPTH, 4, GP pixel buffer entries; power of two, >= 2.

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
soft_clr  in  1  synchronous frame abort; same effect as reset, except frame_cnt is kept
gp_valid  in  1  MEM stage presents a GP pixel
gp_pixel  in  DATA_W  pixel value (AluResult[DATA_W-1:0])
gp_ready  out  1  pixel accepted when gp_valid && gp_ready
mem_we  out  1  write request to output memory
mem_re  out  1  read request to output memory
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  write data
mem_busy  in  1  port busy; request not taken this cycle
mem_rdata  in  DATA_W  read data, valid the cycle after an accepted read
frame_done  out  1  level: full frame stored, awaiting readout
rd_start  in  1  pulse: begin readout (honoured only in DONE)
rd_valid  out  1  readout pixel valid
rd_data  out  DATA_W  readout pixel
rd_last  out  1  with rd_valid: final pixel of frame
rd_ready  in  1  host accepts pixel
frame_cnt  out  16  completed readouts, wraps at 2^16

Behaviour:
- States: FILL, DONE, RD_REQ, RD_WAIT, RD_OUT. Reset state is FILL.
- Reset values: all counters 0, FIFO empty, every output 0 except gp_ready = 1.
- Counters: acc_cnt counts accepted pixels; wr_cnt counts completed writes.
- gp_ready = (state==FILL) && FIFO not full && acc_cnt < PIX_COUNT. The result is combinational from state and counters only.
- Push on a gp handshake; acc_cnt++.
- Write issue: in FILL, when no write is pending and the FIFO is non-empty, pop the head. On the next edge register mem_we=1, mem_addr=wr_cnt, mem_wdata=head.
- Minimum latency from a gp handshake in cycle t to mem_we high is cycle t+1.
- Pending write: a write completes in a cycle where mem_we && !mem_busy; wr_cnt++ on completion.
- While mem_busy is high, mem_we, mem_addr and mem_wdata hold stable.
- Back-to-back writes allowed: one write per cycle when mem_busy stays low.
- Simultaneous push and pop in the same cycle is allowed; FIFO occupancy is unchanged.
- When the completing write has wr_cnt==PIX_COUNT-1: next state DONE, frame_done=1, mem_we=0.
- DONE: gp_ready=0, GP pixels stall upstream. rd_start moves to RD_REQ with read address 0. rd_start is ignored in every other state.
- RD_REQ: mem_re=1, mem_addr=rd_addr. Held while mem_busy; goes to RD_WAIT on the cycle mem_busy is low.
- RD_WAIT: capture mem_rdata into rd_data, then go to RD_OUT.
- RD_OUT: rd_valid=1, rd_last=(rd_addr==PIX_COUNT-1). rd_data stays stable until rd_ready.
- On handshake with rd_last=0: rd_addr++, go to RD_REQ.
- On handshake with rd_last=1: go to FILL, clear all counters, frame_done=0, frame_cnt++.
- frame_done stays 1 through DONE and all readout states.
- No address wraps inside a frame: acc_cnt saturates at PIX_COUNT through the gp_ready gating.
- Reset mid-operation: asynchronously forces the reset values; FIFO contents are discarded. soft_clr does the same at the next edge, frame_cnt kept.
- mem_we and mem_re are never high in the same cycle.

Test Plan:
- PIX_COUNT=8, mem_busy=0, gp_valid held with pixels 0x10..0x17:
  - 8 handshakes; mem_we on 8 consecutive cycles, addr 0..7, data 0x10..0x17.
  - frame_done rises the cycle after the write to addr 7; gp_ready=0 afterwards.
- mem_busy high for 5 cycles during a fill:
  - FIFO fills to 4 entries, then gp_ready=0.
  - mem_addr/mem_wdata hold stable; no write lost or duplicated.
  - Memory contents match the input order.
- Frame complete, rd_start pulse, rd_ready=1:
  - 8 rd_valid beats, rd_data 0x10..0x17, rd_last only on the 8th.
  - Returns to FILL; frame_cnt=1.
- Readout with rd_ready low 3 cycles on beat 2: rd_valid and rd_data hold; no mem_re is issued meanwhile.
- rd_start pulsed during FILL: ignored, no mem_re. Later, in DONE, the readout proceeds normally.
- Reset (rst low) asserted after 5 pixels accepted:
  - All outputs go to reset values immediately.
  - A following 8-pixel frame writes addresses 0..7 with the new data only.
